range_update_scheduler: RTL and testbench

- Shares one iterative range-update datapath (multiply, then restoring divide) among NUM_REQ entropy-decoder lanes.
- Each lane requests range_new = (range_current * cum_prob) / total_prob.
- Grants are round-robin; results return on a single valid/ready response channel tagged with the lane ID.
- Sits between the per-lane Range Calculator front ends and the renormalisation stage.

---
 rtl/range_update_scheduler.sv | 144 ++++++++++++++
 tb/tb_range_update_scheduler.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/range_update_scheduler.sv
// Shared range-update engine: round-robin grant among NUM_REQ lanes, then
// range*cum / total via one multiply cycle and a 32-step restoring divide.
module range_update_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [16*NUM_REQ-1:0]   req_range,
  input  logic [16*NUM_REQ-1:0]   req_cum,
  input  logic [16*NUM_REQ-1:0]   req_total,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic [15:0]             rsp_range,
  output logic                    rsp_overflow,
  output logic                    busy,
  output logic [15:0]             ovf_count
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_e;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q;
  logic [15:0]       range_q, cum_q, total_q;
  logic [31:0]       dividend_q;
  logic [15:0]       rem_q, rem_d;
  logic [4:0]        iter_q;
  logic [ID_W-1:0]   rsp_id_q;
  logic [15:0]       rsp_range_q;
  logic              rsp_ovf_q;
  logic [15:0]       ovf_cnt_q;

  logic              gnt_any;
  logic [ID_W-1:0]   gnt_id;
  logic [15:0]       sel_range, sel_cum, sel_total;
  logic              exc;
  logic [16:0]       rem_shift;
  logic              qbit;

  // Round-robin search starting one past the last granted lane.
  always_comb begin
    int j;
    gnt_any   = 1'b0;
    gnt_id    = '0;
    sel_range = '0;
    sel_cum   = '0;
    sel_total = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      j = (int'(rr_ptr_q) + k) % NUM_REQ;
      if (!gnt_any && req_valid[j]) begin
        gnt_any   = 1'b1;
        gnt_id    = ID_W'(j);
        sel_range = req_range[16*j +: 16];
        sel_cum   = req_cum[16*j +: 16];
        sel_total = req_total[16*j +: 16];
      end
    end
  end

  assign exc = (sel_total == 16'd0) || (sel_cum >= sel_total);

  // The remainder always stays below total, so 16 stored bits plus the
  // incoming dividend bit cover every step.
  assign rem_shift = {rem_q, dividend_q[31]};
  assign qbit      = (rem_shift >= {1'b0, total_q});
  assign rem_d     = qbit ? 16'(rem_shift - {1'b0, total_q}) : rem_shift[15:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (gnt_any) state_d = exc ? DONE : MUL;
      MUL:  state_d = DIV;
      DIV:  if (iter_q == 5'd31) state_d = DONE;
      DONE: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    if (reset_n && state_q == IDLE && gnt_any) req_ready[gnt_id] = 1'b1;
    rsp_valid = (state_q == DONE);
    busy      = (state_q != IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr_q    <= ID_W'(NUM_REQ - 1);
      range_q     <= '0;
      cum_q       <= '0;
      total_q     <= '0;
      dividend_q  <= '0;
      rem_q       <= '0;
      iter_q      <= '0;
      rsp_id_q    <= '0;
      rsp_range_q <= '0;
      rsp_ovf_q   <= 1'b0;
      ovf_cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (gnt_any) begin
          rr_ptr_q  <= gnt_id;
          rsp_id_q  <= gnt_id;
          range_q   <= sel_range;
          cum_q     <= sel_cum;
          total_q   <= sel_total;
          rsp_ovf_q <= exc;
          if (exc) rsp_range_q <= sel_range;
        end
        MUL: begin
          dividend_q  <= 32'(range_q) * 32'(cum_q);
          rem_q       <= '0;
          iter_q      <= '0;
          rsp_range_q <= '0;
        end
        // Quotient bits shift straight into the response register; the upper
        // 16 quotient bits are zero because cum < total.
        DIV: begin
          dividend_q  <= {dividend_q[30:0], 1'b0};
          rem_q       <= rem_d;
          rsp_range_q <= {rsp_range_q[14:0], qbit};
          iter_q      <= iter_q + 5'd1;
        end
        DONE: if (rsp_ready && rsp_ovf_q && ovf_cnt_q != 16'hFFFF)
          ovf_cnt_q <= ovf_cnt_q + 16'd1;
        default: ;
      endcase
    end
  end

  assign rsp_id       = rsp_id_q;
  assign rsp_range    = rsp_range_q;
  assign rsp_overflow = rsp_ovf_q;
  assign ovf_count    = ovf_cnt_q;

endmodule

// File: tb/tb_range_update_scheduler.sv
// Scoreboard bench for range_update_scheduler: expected responses are queued
// at request time from an arithmetic model and popped when rsp_valid shows.
module tb_range_update_scheduler;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [63:0] req_range, req_cum, req_total;
  logic        rsp_valid, rsp_ready;
  logic [1:0]  rsp_id;
  logic [15:0] rsp_range;
  logic        rsp_overflow, busy;
  logic [15:0] ovf_count;

  range_update_scheduler #(.NUM_REQ(4), .ID_W(2)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_range(req_range), .req_cum(req_cum), .req_total(req_total),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_range(rsp_range), .rsp_overflow(rsp_overflow),
    .busy(busy), .ovf_count(ovf_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [1:0] id; logic [15:0] rng; logic ovf;} exp_t;
  exp_t sb[$];
  int checks = 0, passed = 0, exp_ovf = 0;

  function automatic exp_t model(int lane, logic [15:0] r, logic [15:0] c, logic [15:0] t);
    exp_t e;
    logic [31:0] p;
    e.id = 2'(lane);
    if (t == 16'd0 || c >= t) begin
      e.rng = r; e.ovf = 1'b1;
    end else begin
      p = 32'(r) * 32'(c);
      e.rng = 16'(p / 32'(t)); e.ovf = 1'b0;
    end
    return e;
  endfunction

  task automatic drive(input logic [3:0] vmask, input int lane,
                       input logic [15:0] r, input logic [15:0] c, input logic [15:0] t);
    req_range[16*lane +: 16] = r;
    req_cum[16*lane +: 16]   = c;
    req_total[16*lane +: 16] = t;
    req_valid = vmask;
  endtask

  // Returns the number of negedges after the call before rsp_valid, or -1.
  task automatic wait_rsp(output int n);
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) return;
      n++;
    end
    n = -1;
  endtask

  task automatic do_reset;
    reset_n = 1'b0; req_valid = 4'b1111; rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    req_valid = 4'b0000;
    reset_n = 1'b1;
    sb.delete();
    exp_ovf = 0;
    @(negedge clk);
  endtask

  task automatic test_reset;
    reset_n = 1'b0; req_valid = 4'b1111; rsp_ready = 1'b0;
    req_range = '0; req_cum = '0; req_total = '0;
    @(negedge clk); #1;
    checks++;
    if ({req_ready, rsp_valid, busy} !== 6'b0)
      $display("FAIL reset_ctrl: got req_ready=%b rsp_valid=%b busy=%b want 0", req_ready, rsp_valid, busy);
    else passed++;
    checks++;
    if ({rsp_id, rsp_range, rsp_overflow, ovf_count} !== 35'b0)
      $display("FAIL reset_data: got id=%0d range=%h ovf=%b cnt=%0d want 0", rsp_id, rsp_range, rsp_overflow, ovf_count);
    else passed++;
    do_reset();
  endtask

  task automatic test_single;
    int n; exp_t e;
    drive(4'b0010, 1, 16'h8000, 16'h4000, 16'h8000); #1;
    checks++;
    if (req_ready !== 4'b0010 || busy !== 1'b0)
      $display("FAIL single_grant: got req_ready=%b busy=%b want 0010/0", req_ready, busy);
    else passed++;
    sb.push_back(model(1, 16'h8000, 16'h4000, 16'h8000));
    @(posedge clk); #1; req_valid = 4'b0000;
    checks++;
    if (busy !== 1'b1) $display("FAIL single_busy: got %b want 1", busy); else passed++;
    wait_rsp(n);
    checks++;
    if (n != 33) $display("FAIL single_latency: got %0d want 33", n); else passed++;
    e = sb.pop_front();
    checks++;
    if ({rsp_id, rsp_range, rsp_overflow} !== e)
      $display("FAIL single_rsp: got id=%0d range=%h ovf=%b want id=%0d range=%h ovf=%b",
               rsp_id, rsp_range, rsp_overflow, e.id, e.rng, e.ovf);
    else passed++;
    rsp_ready = 1'b1;
    @(posedge clk); #1; rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL single_release: got rsp_valid=%b busy=%b want 0/0", rsp_valid, busy);
    else passed++;
    @(negedge clk);
  endtask

  task automatic test_exception;
    logic [15:0] cs[2] = '{16'h0000, 16'h0100};
    logic [15:0] ts[2] = '{16'h0000, 16'h0100};
    int n; exp_t e;
    for (int i = 0; i < 2; i++) begin
      drive(4'b0100, 2, 16'h1234, cs[i], ts[i]); #1;
      sb.push_back(model(2, 16'h1234, cs[i], ts[i]));
      @(posedge clk); #1; req_valid = 4'b0000;
      wait_rsp(n);
      checks++;
      if (n != 0) $display("FAIL exc_latency: got %0d want 0", n); else passed++;
      e = sb.pop_front();
      checks++;
      if ({rsp_id, rsp_range, rsp_overflow} !== e)
        $display("FAIL exc_rsp: got id=%0d range=%h ovf=%b want id=%0d range=%h ovf=%b",
                 rsp_id, rsp_range, rsp_overflow, e.id, e.rng, e.ovf);
      else passed++;
      rsp_ready = 1'b1;
      @(posedge clk); #1; rsp_ready = 1'b0;
      exp_ovf++;
      @(negedge clk);
    end
    checks++;
    if (ovf_count !== 16'(exp_ovf)) $display("FAIL exc_count: got %0d want %0d", ovf_count, exp_ovf);
    else passed++;
  endtask

  task automatic test_backpressure;
    int n; exp_t e, e0;
    rsp_ready = 1'b0;
    drive(4'b0000, 3, 16'h0500, 16'h0001, 16'h0002);
    drive(4'b0001, 0, 16'hABCD, 16'h0005, 16'h0005); #1;
    e0 = model(0, 16'hABCD, 16'h0005, 16'h0005);
    sb.push_back(e0);
    @(posedge clk); #1; req_valid = 4'b1000;
    wait_rsp(n);
    checks++;
    if (n != 0) $display("FAIL bp_latency: got %0d want 0", n); else passed++;
    e = sb.pop_front();
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (rsp_valid !== 1'b1 || req_ready !== 4'b0000 || {rsp_id, rsp_range, rsp_overflow} !== e)
        $display("FAIL bp_hold: cycle %0d got valid=%b ready=%b id=%0d range=%h ovf=%b want 1/0000 id=%0d range=%h ovf=%b",
                 i, rsp_valid, req_ready, rsp_id, rsp_range, rsp_overflow, e.id, e.rng, e.ovf);
      else passed++;
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 4'b1000)
      $display("FAIL bp_release: got valid=%b busy=%b ready=%b want 0/0/1000", rsp_valid, busy, req_ready);
    else passed++;
    req_valid = 4'b0000; rsp_ready = 1'b0;
    exp_ovf++;
    @(negedge clk);
    checks++;
    if (ovf_count !== 16'(exp_ovf)) $display("FAIL bp_count: got %0d want %0d", ovf_count, exp_ovf);
    else passed++;
  endtask

  task automatic test_round_robin;
    int ord[8] = '{0, 1, 2, 3, 0, 1, 3, 1};
    int n; exp_t e;
    do_reset();
    for (int i = 0; i < 4; i++)
      drive(4'b0000, i, 16'((i + 1) * 4096), 16'((i + 1) * 256 + 1), 16'h2000);
    rsp_ready = 1'b1; req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      int lane;
      lane = ord[k];
      if (k == 5) req_valid = 4'b1010;
      #1;
      checks++;
      if (req_ready !== 4'(1 << lane))
        $display("FAIL rr_grant: step %0d got req_ready=%b want lane %0d", k, req_ready, lane);
      else passed++;
      sb.push_back(model(lane, req_range[16*lane +: 16], req_cum[16*lane +: 16], req_total[16*lane +: 16]));
      @(posedge clk); #1;
      wait_rsp(n);
      e = sb.pop_front();
      checks++;
      if (n != 33 || {rsp_id, rsp_range, rsp_overflow} !== e)
        $display("FAIL rr_rsp: step %0d lat=%0d id=%0d range=%h ovf=%b want lat=33 id=%0d range=%h ovf=%b",
                 k, n, rsp_id, rsp_range, rsp_overflow, e.id, e.rng, e.ovf);
      else passed++;
      @(posedge clk);
      @(negedge clk);
    end
    req_valid = 4'b0000; rsp_ready = 1'b0;
  endtask

  task automatic test_max_operands;
    int n, lane, want_lat;
    logic [15:0] r, c, t;
    exp_t e;
    for (int k = 0; k < 1202; k++) begin
      if (k == 0) begin lane = 3; r = 16'hFFFF; c = 16'hFFFE; t = 16'hFFFF; end
      else if (k == 1) begin lane = 0; r = 16'h0001; c = 16'h0001; t = 16'hFFFF; end
      else begin
        lane = $urandom_range(0, 3);
        r = 16'($urandom);
        t = 16'($urandom);
        if ($urandom_range(0, 15) == 0) c = 16'($urandom);
        else if (t == 16'd0) c = 16'd0;
        else c = 16'($urandom_range(0, int'(t) - 1));
      end
      drive(4'(1 << lane), lane, r, c, t); #1;
      checks++;
      if (req_ready !== 4'(1 << lane))
        $display("FAIL rand_grant: req %0d got %b want lane %0d", k, req_ready, lane);
      else passed++;
      e = model(lane, r, c, t);
      sb.push_back(e);
      want_lat = e.ovf ? 0 : 33;
      @(posedge clk); #1; req_valid = 4'b0000;
      wait_rsp(n);
      e = sb.pop_front();
      checks++;
      if (n != want_lat || {rsp_id, rsp_range, rsp_overflow} !== e)
        $display("FAIL rand_rsp: req %0d r=%h c=%h t=%h lat=%0d id=%0d range=%h ovf=%b want lat=%0d id=%0d range=%h ovf=%b",
                 k, r, c, t, n, rsp_id, rsp_range, rsp_overflow, want_lat, e.id, e.rng, e.ovf);
      else passed++;
      if (e.ovf) exp_ovf++;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      rsp_ready = 1'b1;
      @(posedge clk); #1; rsp_ready = 1'b0;
      @(negedge clk);
    end
    checks++;
    if (ovf_count !== 16'(exp_ovf)) $display("FAIL rand_count: got %0d want %0d", ovf_count, exp_ovf);
    else passed++;
  endtask

  task automatic test_reset_mid;
    int n; bit stale; exp_t e;
    drive(4'b0100, 2, 16'h8000, 16'h4000, 16'h8000); #1;
    sb.push_back(model(2, 16'h8000, 16'h4000, 16'h8000));
    @(posedge clk); #1; req_valid = 4'b0000;
    repeat (17) @(negedge clk);
    reset_n = 1'b0; req_valid = 4'b1111; #1;
    checks++;
    if ({req_ready, rsp_valid, busy, rsp_id, rsp_range, rsp_overflow, ovf_count} !== 41'b0)
      $display("FAIL midreset_outputs: ready=%b valid=%b busy=%b id=%0d range=%h ovf=%b cnt=%0d want all 0",
               req_ready, rsp_valid, busy, rsp_id, rsp_range, rsp_overflow, ovf_count);
    else passed++;
    sb.delete(); exp_ovf = 0;
    @(negedge clk);
    req_valid = 4'b0000; reset_n = 1'b1;
    stale = 1'b0;
    repeat (4) begin @(negedge clk); if (rsp_valid !== 1'b0 || busy !== 1'b0) stale = 1'b1; end
    checks++;
    if (stale) $display("FAIL midreset_stale: got activity after reset want none"); else passed++;
    drive(4'b1111, 0, 16'h0100, 16'h0003, 16'h0007); #1;
    checks++;
    if (req_ready !== 4'b0001) $display("FAIL midreset_grant: got %b want 0001", req_ready); else passed++;
    sb.push_back(model(0, 16'h0100, 16'h0003, 16'h0007));
    @(posedge clk); #1; req_valid = 4'b0000;
    wait_rsp(n);
    e = sb.pop_front();
    checks++;
    if (n != 33 || {rsp_id, rsp_range, rsp_overflow} !== e)
      $display("FAIL midreset_rsp: lat=%0d id=%0d range=%h ovf=%b want lat=33 id=%0d range=%h ovf=%b",
               n, rsp_id, rsp_range, rsp_overflow, e.id, e.rng, e.ovf);
    else passed++;
    rsp_ready = 1'b1;
    @(posedge clk); #1; rsp_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_exception();
    test_backpressure();
    test_round_robin();
    test_max_operands();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    repeat (95000) @(posedge clk);
    $display("FAIL watchdog: got no completion within 95000 cycles want completion");
    $fatal(1, "watchdog expired");
  end
endmodule
